// File: rtl/an_scan_driver.sv
// ---------------------------------------------------------------------------
// an_scan_driver
//
// Purpose:
//   Time-multiplexed anode scanner for the ALU 7-segment display. The ALU
//   opcode selects an enable mask. The scanner then walks through the enabled
//   digits only, lowest index first, one digit per refresh tick. Optional
//   all-off blank slots can follow each digit to suppress ghosting. The
//   outputs drive the segment mux (digit_idx) and the board anode pins (an_n).
//
// Parameters:
//   N_DIGITS     number of display digits
//   PRESCALE     clk cycles per refresh tick (>= 2)
//   BLANK_TICKS  refresh ticks with every anode off between two digits
//   MASK_ARITH   enable mask for op 1 (add) and op 4 (subtract)
//   MASK_LOGIC   enable mask for every other op
//
// Ports:
//   clk          in   1                  system clock
//   rst_n        in   1                  asynchronous reset, active low
//   op           in   3                  ALU operation code
//   an_n         out  N_DIGITS           anode drive, active low (1 = off)
//   digit_idx    out  $clog2(N_DIGITS)   index of the lit digit
//   frame_start  out  1                  one-cycle pulse at each new frame
// ---------------------------------------------------------------------------
module an_scan_driver #(
    parameter int                    N_DIGITS    = 8,
    parameter int                    PRESCALE    = 100000,
    parameter int                    BLANK_TICKS = 0,
    parameter logic [N_DIGITS-1:0]   MASK_ARITH  = N_DIGITS'(8'b0000_0111),
    parameter logic [N_DIGITS-1:0]   MASK_LOGIC  = N_DIGITS'(8'b1100_0011),
    localparam int                   IDX_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           op,
    output logic [N_DIGITS-1:0]  an_n,
    output logic [IDX_W-1:0]     digit_idx,
    output logic                 frame_start
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BL_W = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    // Blank counter runs 0..BLANK_TICKS-1; unused when BLANK_TICKS is 0.
    localparam logic [BL_W-1:0] BL_LAST = BL_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [IDX_W-1:0] lowest_bit(input logic [N_DIGITS-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    // True when some bit strictly above idx is set.
    function automatic logic has_higher(input logic [N_DIGITS-1:0] m,
                                        input logic [IDX_W-1:0]    idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (m[i] && (i > int'(idx))) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    // Index of the nearest set bit strictly above idx (idx if none).
    function automatic logic [IDX_W-1:0] next_higher(input logic [N_DIGITS-1:0] m,
                                                     input logic [IDX_W-1:0]    idx);
        logic [IDX_W-1:0] r;
        r = idx;
        // Scanning downward lets the closest qualifying bit win.
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(idx))) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [N_DIGITS-1:0] anode_pattern(input logic [IDX_W-1:0] idx);
        logic [N_DIGITS-1:0] r;
        r = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (int'(idx) == i) begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [PS_W-1:0]     ps_q;
    logic [BL_W-1:0]     bl_q,    bl_d;
    logic [N_DIGITS-1:0] mask_q,  mask_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [N_DIGITS-1:0] an_q,    an_d;
    logic                fs_q,    fs_d;

    logic                tick;
    logic [N_DIGITS-1:0] mask_dec;
    logic                advance;

    // -----------------------------------------------------------------------
    // Refresh prescaler: free-running 0..PRESCALE-1, tick on the last count.
    // -----------------------------------------------------------------------
    assign tick = (ps_q == PS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q <= '0;
        end else if (tick) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Opcode to enable-mask decode. Only sampled at frame boundaries.
    // -----------------------------------------------------------------------
    always_comb begin
        mask_dec = MASK_LOGIC;
        if ((op == 3'd1) || (op == 3'd4)) begin
            mask_dec = MASK_ARITH;
        end
    end

    // -----------------------------------------------------------------------
    // Scan FSM: next state and registered-output values.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        bl_d    = bl_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        fs_d    = 1'b0;
        advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    mask_d = mask_dec;
                    if (|mask_dec) begin
                        idx_d   = lowest_bit(mask_dec);
                        state_d = S_SHOW;
                        fs_d    = 1'b1;
                    end
                end
            end

            S_SHOW: begin
                if (tick) begin
                    if (BLANK_TICKS > 0) begin
                        state_d = S_BLANK;
                        bl_d    = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end

            S_BLANK: begin
                if (tick) begin
                    if (bl_q == BL_LAST) begin
                        advance = 1'b1;
                    end else begin
                        bl_d = bl_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Move to the next enabled digit, or close the frame and relatch the
        // mask from the current opcode. The relatch is the only point where
        // an opcode change can take effect.
        if (advance) begin
            if (has_higher(mask_q, idx_q)) begin
                idx_d   = next_higher(mask_q, idx_q);
                state_d = S_SHOW;
            end else begin
                mask_d = mask_dec;
                if (|mask_dec) begin
                    idx_d   = lowest_bit(mask_dec);
                    state_d = S_SHOW;
                    fs_d    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
        end

        // Anodes follow the next state so the outputs can be registered
        // without adding a cycle of latency.
        an_d = '1;
        if (state_d == S_SHOW) begin
            an_d = anode_pattern(idx_d);
        end
    end

    // -----------------------------------------------------------------------
    // State and output registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bl_q    <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bl_q    <= bl_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            fs_q    <= fs_d;
        end
    end

    assign an_n        = an_q;
    assign digit_idx   = idx_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_an_scan_driver.sv
module tb_an_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] op;

    logic [7:0] d_an  [3];
    logic [2:0] d_idx [3];
    logic       d_fs  [3];

    // Instance 0: base configuration. Instance 1: one blank tick between
    // digits. Instance 2: empty arithmetic mask.
    an_scan_driver #(.N_DIGITS(8), .PRESCALE(4), .BLANK_TICKS(0),
                     .MASK_ARITH(8'h07), .MASK_LOGIC(8'hC3)) dut0 (
        .clk(clk), .rst_n(rst_n), .op(op),
        .an_n(d_an[0]), .digit_idx(d_idx[0]), .frame_start(d_fs[0]));

    an_scan_driver #(.N_DIGITS(8), .PRESCALE(4), .BLANK_TICKS(1),
                     .MASK_ARITH(8'h07), .MASK_LOGIC(8'hC3)) dut1 (
        .clk(clk), .rst_n(rst_n), .op(op),
        .an_n(d_an[1]), .digit_idx(d_idx[1]), .frame_start(d_fs[1]));

    an_scan_driver #(.N_DIGITS(8), .PRESCALE(4), .BLANK_TICKS(0),
                     .MASK_ARITH(8'h00), .MASK_LOGIC(8'hC3)) dut2 (
        .clk(clk), .rst_n(rst_n), .op(op),
        .an_n(d_an[2]), .digit_idx(d_idx[2]), .frame_start(d_fs[2]));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is a list of display slots: each enabled digit, ascending,
    // followed by BLANK_TICKS blank slots. One slot per refresh tick.
    typedef struct packed {
        logic [2:0] idx;
        logic       blank;
    } slot_t;

    localparam int         PRE    = 4;
    localparam int         BT [3] = '{0, 1, 0};
    localparam logic [7:0] MA [3] = '{8'h07, 8'h07, 8'h00};
    localparam logic [7:0] ML     = 8'hC3;

    slot_t      fr    [3][16];
    int         flen  [3];
    int         fpos  [3];
    int         ps    [3];
    logic [7:0] m_an  [3];
    logic [2:0] m_idx [3];
    logic       m_fs  [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            flen[k]  = 0;
            fpos[k]  = 0;
            ps[k]    = 0;
            m_an[k]  = 8'hFF;
            m_idx[k] = 3'd0;
            m_fs[k]  = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [7:0] m;
        bit         tk;
        for (int k = 0; k < 3; k++) begin
            m_fs[k] = 1'b0;
            tk      = (ps[k] == PRE - 1);
            ps[k]   = tk ? 0 : ps[k] + 1;
            if (tk) begin
                if (fpos[k] < flen[k]) fpos[k]++;
                if (fpos[k] >= flen[k]) begin
                    m       = ((op == 3'd1) || (op == 3'd4)) ? MA[k] : ML;
                    flen[k] = 0;
                    fpos[k] = 0;
                    for (int b = 0; b < 8; b++) begin
                        if (m[b]) begin
                            fr[k][flen[k]] = {3'(b), 1'b0};
                            flen[k]++;
                            for (int t = 0; t < BT[k]; t++) begin
                                fr[k][flen[k]] = {3'(b), 1'b1};
                                flen[k]++;
                            end
                        end
                    end
                    if (flen[k] > 0) m_fs[k] = 1'b1;
                end
            end
            if (fpos[k] < flen[k]) begin
                m_idx[k] = fr[k][fpos[k]].idx;
                m_an[k]  = fr[k][fpos[k]].blank ? 8'hFF : ~(8'h01 << fr[k][fpos[k]].idx);
            end else begin
                m_an[k] = 8'hFF;
            end
        end
    endtask

    task automatic cmp_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model_an%0d", k),  d_an[k],  m_an[k]);
            chk($sformatf("model_idx%0d", k), d_idx[k], m_idx[k]);
            chk($sformatf("model_fs%0d", k),  d_fs[k],  m_fs[k]);
        end
    endtask

    // One clock: model follows the active edge, comparison on the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        @(negedge clk);
        cmp_all();
    endtask

    // Hand-computed anode patterns per 4-cycle group after reset release,
    // with op switching from 1 to 2 just before clock 21.
    logic [7:0] g0 [11] = '{8'hFF, 8'hFE, 8'hFD, 8'hFB, 8'hFE, 8'hFD, 8'hFB, 8'hFE, 8'hFD, 8'hBF, 8'h7F};
    logic [7:0] g1 [11] = '{8'hFF, 8'hFE, 8'hFF, 8'hFD, 8'hFF, 8'hFB, 8'hFF, 8'hFE, 8'hFF, 8'hFD, 8'hFF};
    logic [7:0] g2 [11] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFD, 8'hBF, 8'h7F, 8'hFE};

    initial begin
        op    = 3'd1;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_an%0d", k),  d_an[k],  8'hFF);
            chk($sformatf("rst_idx%0d", k), d_idx[k], 3'd0);
            chk($sformatf("rst_fs%0d", k),  d_fs[k],  1'b0);
        end

        // Directed: op=1 scan, op change mid-frame, empty mask then logic op.
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            chk("lit_an0", d_an[0], g0[k/4]);
            chk("lit_an1", d_an[1], g1[k/4]);
            chk("lit_an2", d_an[2], g2[k/4]);
            chk("lit_fs0", d_fs[0], (k == 4) || (k == 16) || (k == 28));
            chk("lit_fs1", d_fs[1], (k == 4) || (k == 28));
            chk("lit_fs2", d_fs[2], (k == 24) || (k == 40));
            if (k == 20) op = 3'd2;
        end

        // Run on to digit 6 of the next frame, then reset asynchronously.
        repeat (13) step();
        chk("lit_an0_d6", d_an[0], 8'hBF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_an0",  d_an[0],  8'hFF);
        chk("async_idx0", d_idx[0], 3'd0);
        chk("async_fs0",  d_fs[0],  1'b0);
        chk("async_an1",  d_an[1],  8'hFF);
        model_reset();
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 3) chk("rel_an0_k3", d_an[0], 8'hFF);
            if (k == 4) begin
                chk("rel_an0_k4", d_an[0], 8'hFE);
                chk("rel_fs0_k4", d_fs[0], 1'b1);
            end
            if (k == 8) chk("rel_an0_k8", d_an[0], 8'hFD);
        end

        // Randomized: opcode changes and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            step();
            if ($urandom_range(0, 11) == 0) op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                model_reset();
                repeat ($urandom_range(1, 3)) step();
                rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
